aes128_round_seq: RTL and testbench

- Iterative AES-128 encryption sequencer.
- Owns the state register, the round-key register and the round counter.
- Drives one shared full-round datapath (SubBytes → ShiftRows → MixColumns → AddRoundKey) once per cycle, plus a final-round path with no MixColumns.
- Sits between a block-level producer and consumer, with valid/ready handshakes on both sides.

---
 rtl/aes_pkg.sv | 76 +++++++
 rtl/aes_key_step.sv | 37 +++
 rtl/shift_rows.sv | 18 +
 rtl/sub_bytes.sv | 11 +
 rtl/aes128_round_seq.sv | 133 +++++++++++++
 tb/tb_aes128_round_seq.sv | 355 +++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM state, round constants and the GF(2^8)
// helpers behind SubBytes and MixColumns.
package aes_pkg;

    localparam int BLK_W  = 128;
    localparam int AES_NR = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } aes_state_e;

    localparam logic [7:0] RCON_TAB [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Indices outside 1..10 only occur while idle; return 0 there.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        if (idx >= 4'd1 && idx <= 4'd10) begin
            return RCON_TAB[idx - 4'd1];
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254, so 0 maps to 0) plus the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = gf_mul(x, x);
        for (int i = 1; i < 8; i++) begin
            r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [BLK_W-1:0] mix_columns(input logic [BLK_W-1:0] s);
        return {mix_column(s[127:96]), mix_column(s[95:64]),
                mix_column(s[63:32]),  mix_column(s[31:0])};
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step: next 4-word round key from the current key and rc.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] key_in,
    input  logic [7:0]       rc,
    output logic [BLK_W-1:0] key_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w;
    logic [31:0] sub_w;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    assign w0    = key_in[127:96];
    assign w1    = key_in[95:64];
    assign w2    = key_in[63:32];
    assign w3    = key_in[31:0];
    assign rot_w = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sub
        sub_bytes u_sb (
            .din  (rot_w[8*i +: 8]),
            .dout (sub_w[8*i +: 8])
        );
    end

    assign t  = sub_w ^ {rc, 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/shift_rows.sv
// AES ShiftRows on a column-major 128-bit state: row r rotates left by r columns.
module shift_rows
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] din,
    output logic [BLK_W-1:0] dout
);

    always_comb begin
        dout = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                dout[127 - 8*(r + 4*c) -: 8] = din[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            end
        end
    end

endmodule

// File: rtl/sub_bytes.sv
// Single-byte AES S-box lookup, combinational.
module sub_bytes
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = sbox(din);

endmodule

// File: rtl/aes128_round_seq.sv
// Iterative AES-128 encryptor: one round per clock, valid/ready on both sides.
// Optional completed-block counter on blk_cnt when AES_PERF_CNT_EN is defined.
module aes128_round_seq
    import aes_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int NR    = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLK_W-1:0]   in_text,
    input  logic [BLK_W-1:0]   in_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLK_W-1:0]   out_data,
    output logic               busy
`ifdef AES_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   blk_cnt
`endif
);

    if (NR != AES_NR || CNT_W < 1) begin : g_bad_cfg
        $error("aes128_round_seq: NR must be 10 and CNT_W at least 1");
    end

    aes_state_e       state_q, state_d;
    logic [BLK_W-1:0] st_q, st_d;
    logic [BLK_W-1:0] rkey_q, rkey_d;
    logic [3:0]       rnd_q, rnd_d;

    logic [BLK_W-1:0] nk;
    logic [BLK_W-1:0] sb;
    logic [BLK_W-1:0] sr;

    aes_key_step u_key_step (
        .key_in  (rkey_q),
        .rc      (rcon(rnd_q)),
        .key_out (nk)
    );

    // SubBytes/ShiftRows are shared by the full round and the final round.
    for (genvar i = 0; i < 16; i++) begin : g_sub
        sub_bytes u_sb (
            .din  (st_q[8*i +: 8]),
            .dout (sb[8*i +: 8])
        );
    end

    shift_rows u_sr (
        .din  (sb),
        .dout (sr)
    );

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rkey_d  = rkey_q;
        rnd_d   = rnd_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    st_d    = in_text ^ in_key;
                    rkey_d  = in_key;
                    rnd_d   = 4'd1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                st_d   = mix_columns(sr) ^ nk;
                rkey_d = nk;
                rnd_d  = rnd_q + 4'd1;
                if (rnd_q == 4'd9) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                st_d    = sr ^ nk;
                rkey_d  = nk;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            st_q    <= '0;
            rkey_q  <= '0;
            rnd_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rkey_q  <= rkey_d;
            rnd_q   <= rnd_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ROUND) || (state_q == FINAL);
    assign out_data  = out_valid ? st_q : '0;

`ifdef AES_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign blk_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_aes128_round_seq.sv
// Self-checking bench for aes128_round_seq using FIPS-197 known-answer vectors.
module tb_aes128_round_seq;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_text = '0;
    logic [127:0] in_key = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         busy;
`ifdef AES_PERF_CNT_EN
    logic [1:0]   blk_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [127:0] exp_q[$];

`ifdef AES_PERF_CNT_EN
    aes128_round_seq #(.CNT_W(2), .NR(10)) dut (
`else
    aes128_round_seq #(.CNT_W(32), .NR(10)) dut (
`endif
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_text   (in_text),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef AES_PERF_CNT_EN
        ,
        .blk_cnt   (blk_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_accept(input logic [127:0] t, input logic [127:0] k,
                                output int acc_cyc, output bit ok);
        ok       = 1'b0;
        acc_cyc  = -1;
        in_text  = t;
        in_key   = k;
        in_valid = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (in_ready) begin
                step();
                acc_cyc = cyc;
                ok      = 1'b1;
                break;
            end
            step();
        end
        in_valid = 1'b0;
        in_text  = {$urandom, $urandom, $urandom, $urandom};
        in_key   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_valid(output int v_cyc, output bit ok);
        ok    = 1'b0;
        v_cyc = -1;
        for (int n = 0; n < 40; n++) begin
            if (out_valid) begin
                ok    = 1'b1;
                v_cyc = cyc;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        n_tests++;
        if (out_data !== 128'h0) begin
            n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data);
        end
`ifdef AES_PERF_CNT_EN
        n_tests++;
        if (blk_cnt !== 2'd0) begin
            n_fail++; $display("FAIL reset_blk_cnt: got %0d expected 0", blk_cnt);
        end
`endif
    endtask

    task automatic test_vector(input string name, input logic [127:0] pt,
                               input logic [127:0] key, input logic [127:0] ct);
        int acc_cyc;
        int v_cyc;
        bit ok;
        logic [127:0] exp;
        drive_accept(pt, key, acc_cyc, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL %s_accept: got no accept expected accept", name);
            return;
        end
        exp_q.push_back(ct);
        n_tests++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL %s_busy: got busy=%b in_ready=%b expected 1/0", name, busy, in_ready);
        end
        wait_valid(v_cyc, ok);
        exp = exp_q.pop_front();
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL %s_out_timeout: got no out_valid expected out_valid", name);
            return;
        end
        n_tests++;
        if (v_cyc - acc_cyc !== 10) begin
            n_fail++; $display("FAIL %s_latency: got %0d expected 10", name, v_cyc - acc_cyc);
        end
        n_tests++;
        if (out_data !== exp) begin
            n_fail++; $display("FAIL %s_data: got %h expected %h", name, out_data, exp);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s_release: got out_valid=%b in_ready=%b expected 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        int acc_cyc;
        int v_cyc;
        bit ok;
        bit bad;
        logic [127:0] exp;
        drive_accept(PT_B, KEY_B, acc_cyc, ok);
        exp_q.push_back(CT_B);
        wait_valid(v_cyc, ok);
        exp = exp_q.pop_front();
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL bp_out_timeout: got no out_valid expected out_valid");
            return;
        end
        n_tests++;
        if (out_data !== exp) begin
            n_fail++; $display("FAIL bp_data: got %h expected %h", out_data, exp);
        end
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = (i % 3 == 0);
            in_text  = {$urandom, $urandom, $urandom, $urandom};
            in_key   = {$urandom, $urandom, $urandom, $urandom};
            step();
            if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
                if (!bad) begin
                    $display("FAIL bp_hold: got out_valid=%b in_ready=%b data=%h expected 1/0 %h",
                             out_valid, in_ready, out_data, exp);
                end
                bad = 1'b1;
            end
        end
        n_tests++;
        if (bad) n_fail++;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        step();
        step();
        n_tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_spurious: got busy=%b out_valid=%b expected 0/0", busy, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] pts [2];
        logic [127:0] keys[2];
        logic [127:0] cts [2];
        int acc_at[2];
        int n_acc;
        int n_rcv;
        bit acc_now;
        bit out_now;
        logic [127:0] d;
        logic [127:0] exp;
        pts[0] = PT_B; keys[0] = KEY_B; cts[0] = CT_B;
        pts[1] = PT_C; keys[1] = KEY_C; cts[1] = CT_C;
        acc_at[0] = 0; acc_at[1] = 0;
        n_acc = 0;
        n_rcv = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_text   = pts[0];
        in_key    = keys[0];
        for (int n = 0; n < 80 && n_rcv < 2; n++) begin
            acc_now = in_valid && in_ready;
            out_now = out_valid && out_ready;
            d = out_data;
            step();
            if (acc_now) begin
                acc_at[n_acc] = cyc;
                exp_q.push_back(cts[n_acc]);
                n_acc++;
                if (n_acc < 2) begin
                    in_text = pts[n_acc];
                    in_key  = keys[n_acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_now) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_unexpected: got %h expected no output", d);
                end else begin
                    exp = exp_q.pop_front();
                    if (d !== exp) begin
                        n_fail++; $display("FAIL b2b_data%0d: got %h expected %h", n_rcv, d, exp);
                    end
                end
                n_rcv++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_tests++;
        if (n_rcv != 2) begin
            n_fail++; $display("FAIL b2b_count: got %0d expected 2", n_rcv);
        end
        n_tests++;
        if (n_acc != 2 || acc_at[1] - acc_at[0] != 12) begin
            n_fail++; $display("FAIL b2b_period: got %0d expected 12", acc_at[1] - acc_at[0]);
        end
    endtask

    task automatic test_reset_mid();
        int acc_cyc;
        bit ok;
        bit bad;
        drive_accept(PT_C, KEY_C, acc_cyc, ok);
        exp_q.push_back(CT_C);
        for (int i = 0; i < 5; i++) step();
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_ctrl: got out_valid=%b in_ready=%b busy=%b expected 0/1/0",
                               out_valid, in_ready, busy);
        end
        n_tests++;
        if (out_data !== 128'h0) begin
            n_fail++; $display("FAIL rst_mid_data: got %h expected 0", out_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL rst_mid_no_output: got out_valid=1 expected 0");
        end
        test_vector("rst_c1", PT_C, KEY_C, CT_C);
    endtask

`ifdef AES_PERF_CNT_EN
    task automatic test_perf_cnt();
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        test_vector("cnt1", PT_B, KEY_B, CT_B);
        test_vector("cnt2", PT_C, KEY_C, CT_C);
        test_vector("cnt3", PT_B, KEY_B, CT_B);
        n_tests++;
        if (blk_cnt !== 2'd3) begin
            n_fail++; $display("FAIL cnt_three: got %0d expected 3", blk_cnt);
        end
        test_vector("cnt4", PT_C, KEY_C, CT_C);
        test_vector("cnt5", PT_B, KEY_B, CT_B);
        n_tests++;
        if (blk_cnt !== 2'd3) begin
            n_fail++; $display("FAIL cnt_saturate: got %0d expected 3", blk_cnt);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        step();
        test_vector("fips_b", PT_B, KEY_B, CT_B);
        test_vector("fips_c1", PT_C, KEY_C, CT_C);
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef AES_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
